// File: rtl/cozy_mem_pkg.sv
// Shared widths, data types and byte-write-enable encodings for the cozy memory blocks.
package cozy_mem_pkg;

    localparam int WORD_W = 16;
    localparam int BYTE_W = 8;

    typedef logic [BYTE_W-1:0] byte_t;
    typedef logic [WORD_W-1:0] word_t;

    localparam logic [1:0] BWE_NONE = 2'b00;
    localparam logic [1:0] BWE_LO   = 2'b01;
    localparam logic [1:0] BWE_HI   = 2'b10;
    localparam logic [1:0] BWE_WORD = 2'b11;

    // Low byte of a word, used for byte stores which always take din[7:0].
    function automatic byte_t lo_byte(input word_t w);
        return w[BYTE_W-1:0];
    endfunction

    // High byte of a word.
    function automatic byte_t hi_byte(input word_t w);
        return w[WORD_W-1:BYTE_W];
    endfunction

endpackage

// File: rtl/cozy_byte_lane.sv
// One 8-bit wide, 2**BITS deep lane of the cozy byte RAM.
// Synchronous write, registered read with an asynchronously cleared output register.
// Optional macro COZY_BYTE_RAM_WRITE_FIRST_EN: when defined, a read of the entry being
// written returns the new byte; otherwise the pre-write byte is returned.
module cozy_byte_lane
    import cozy_mem_pkg::*;
#(
    parameter int BITS = 10
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [BITS-1:0] idx,
    input  logic            we,
    input  byte_t           wdata,
    output byte_t           rdata
);

    byte_t mem [0:(2**BITS)-1];

    // Storage write; contents are never cleared and writes ignore reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx] <= wdata;
        end
    end

    // Read register, loaded every edge and cleared while reset is held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else begin
`ifdef COZY_BYTE_RAM_WRITE_FIRST_EN
            rdata <= we ? wdata : mem[idx];
`else
            rdata <= mem[idx];
`endif
        end
    end

endmodule

// File: rtl/cozy_byte_ram.sv
// Byte-addressable little-endian 16-bit single-port RAM for the cozy CPU core.
// Two byte lanes: ram_lo holds even bytes, ram_hi holds odd bytes of each word.
// Top steers write data into the lanes and builds dout (word or zero-extended odd byte).
// Optional macro COZY_BYTE_RAM_WRITE_FIRST_EN selects write-first read-during-write
// behaviour inside the lanes; the default is read-first.
module cozy_byte_ram
    import cozy_mem_pkg::*;
#(
    parameter int BITS = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] addr,
    input  word_t       din,
    input  logic [1:0]  bwe,
    output word_t       dout
);

    logic [BITS-1:0] idx;
    logic            odd;
    logic            lo_we;
    logic            hi_we;
    byte_t           lo_wdata;
    byte_t           hi_wdata;
    byte_t           lo_rdata;
    byte_t           hi_rdata;
    logic            odd_q;
    logic            unused_addr_hi;

    // Upper address bits are deliberately dropped so addresses wrap around the depth.
    assign unused_addr_hi = ^addr[15:BITS+1];

    assign idx = addr[BITS:1];
    assign odd = addr[0];

    // Lane steering: odd byte stores go to the hi lane from din[7:0]; a hi enable on an
    // odd address would be misaligned and writes nothing.
    always_comb begin
        lo_we    = 1'b0;
        hi_we    = 1'b0;
        lo_wdata = lo_byte(din);
        hi_wdata = hi_byte(din);
        if (odd) begin
            hi_we    = bwe[0];
            hi_wdata = lo_byte(din);
        end else begin
            lo_we = bwe[0];
            hi_we = bwe[1];
        end
    end

    cozy_byte_lane #(.BITS(BITS)) ram_lo (
        .clk   (clk),
        .rst_n (rst_n),
        .idx   (idx),
        .we    (lo_we),
        .wdata (lo_wdata),
        .rdata (lo_rdata)
    );

    cozy_byte_lane #(.BITS(BITS)) ram_hi (
        .clk   (clk),
        .rst_n (rst_n),
        .idx   (idx),
        .we    (hi_we),
        .wdata (hi_wdata),
        .rdata (hi_rdata)
    );

    // Remember which kind of read was issued so the output mux lines up with the lane registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            odd_q <= 1'b0;
        end else begin
            odd_q <= odd;
        end
    end

    assign dout = odd_q ? {8'h00, hi_rdata} : {hi_rdata, lo_rdata};

endmodule

// File: tb/tb_cozy_byte_ram.sv
// Self-checking bench for cozy_byte_ram with BITS=4 (16 words, 32 bytes).
// A byte-addressed reference model produces the expected dout for each cycle; the
// expectation is queued when stimulus is driven and compared once the DUT has produced it.
// Define COZY_BYTE_RAM_WRITE_FIRST_EN for both RTL and bench to check write-first mode.
`timescale 1ns/1ps
module tb_cozy_byte_ram;
    import cozy_mem_pkg::*;

    localparam int BITS = 4;
    localparam int NBYTES = 2**(BITS+1);

    typedef struct {
        word_t val;
        string name;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [15:0] addr;
    word_t       din;
    logic [1:0]  bwe;
    word_t       dout;

    byte_t model [0:NBYTES-1];
    exp_t  sb [$];
    int    n_compared;
    int    n_mismatched;

    cozy_byte_ram #(.BITS(BITS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .addr  (addr),
        .din   (din),
        .bwe   (bwe),
        .dout  (dout)
    );

    // Free-running clock, 10 ns period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference read in byte-address terms.
    function automatic word_t model_read(input logic [15:0] a);
        int b;
        b = int'(a[BITS:0]);
        if (a[0]) return {8'h00, model[b]};
        return {model[b+1], model[b]};
    endfunction

    // Reference write in byte-address terms.
    function automatic void model_write(input logic [15:0] a, input word_t d, input logic [1:0] w);
        int b;
        b = int'(a[BITS:0]);
        if (a[0]) begin
            if (w[0]) model[b] = d[7:0];
        end else begin
            if (w[0]) model[b]   = d[7:0];
            if (w[1]) model[b+1] = d[15:8];
        end
    endfunction

    // Drive one cycle, queue the expected dout, then compare after the edge.
    // Expectations still containing undefined memory bytes are not compared.
    task automatic applyStimulus(input logic [15:0] a, input word_t d, input logic [1:0] w, input string nm);
        exp_t e;
        exp_t got;
        @(negedge clk);
        addr = a;
        din  = d;
        bwe  = w;
`ifdef COZY_BYTE_RAM_WRITE_FIRST_EN
        model_write(a, d, w);
        e.val = model_read(a);
`else
        e.val = model_read(a);
        model_write(a, d, w);
`endif
        e.name = nm;
        sb.push_back(e);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        if (!$isunknown(got.val)) begin
            n_compared++;
            if (dout !== got.val) begin
                n_mismatched++;
                $display("[TB] FAIL %s: dout=%h expected=%h", got.name, dout, got.val);
            end
        end
    endtask

    task automatic test_reset;
        n_compared++;
        if (dout !== 16'h0000) begin
            n_mismatched++;
            $display("[TB] FAIL reset_dout: dout=%h expected=0000", dout);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_word_writes;
        applyStimulus(16'h0000, 16'h1234, BWE_WORD, "ww_a0");
        applyStimulus(16'h0002, 16'h5678, BWE_WORD, "ww_a2");
        applyStimulus(16'h0004, 16'h9ABC, BWE_WORD, "ww_a4");
        applyStimulus(16'h0006, 16'hCDEF, BWE_WORD, "ww_a6");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(16'(2*i), 16'h0000, BWE_NONE, $sformatf("ww_rd%0d", i));
        end
    endtask

    task automatic test_byte_writes;
        applyStimulus(16'h0000, 16'hABCD, BWE_LO, "lo_wr");
        applyStimulus(16'h0000, 16'h0000, BWE_NONE, "lo_rd");
        applyStimulus(16'h0001, 16'hBCDE, BWE_LO, "odd_wr");
        applyStimulus(16'h0000, 16'h0000, BWE_NONE, "rd_a0");
        applyStimulus(16'h0001, 16'h0000, BWE_NONE, "rd_a1");
        applyStimulus(16'h0002, 16'h0000, BWE_NONE, "rd_a2");
        applyStimulus(16'h0002, 16'h7700, BWE_HI, "hi_wr");
        applyStimulus(16'h0002, 16'h0000, BWE_NONE, "hi_rd");
    endtask

    task automatic test_reset_mid_read;
        applyStimulus(16'h0000, 16'h0000, BWE_NONE, "pre_rst_rd");
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_compared++;
        if (dout !== 16'h0000) begin
            n_mismatched++;
            $display("[TB] FAIL rst_async: dout=%h expected=0000", dout);
        end
        // Write during reset must still land in memory.
        addr = 16'h0008;
        din  = 16'h4242;
        bwe  = BWE_WORD;
        model_write(16'h0008, 16'h4242, BWE_WORD);
        @(posedge clk);
        #1;
        n_compared++;
        if (dout !== 16'h0000) begin
            n_mismatched++;
            $display("[TB] FAIL rst_hold: dout=%h expected=0000", dout);
        end
        @(negedge clk);
        bwe   = BWE_NONE;
        rst_n = 1'b1;
        applyStimulus(16'h0000, 16'h0000, BWE_NONE, "post_rst_a0");
        applyStimulus(16'h0001, 16'h0000, BWE_NONE, "post_rst_a1");
        applyStimulus(16'h0008, 16'h0000, BWE_NONE, "wr_in_rst");
    endtask

    task automatic test_read_during_write;
        applyStimulus(16'h0004, 16'h1111, BWE_WORD, "rdw_word");
        applyStimulus(16'h0007, 16'hAA55, BWE_LO, "rdw_odd");
        applyStimulus(16'h0006, 16'h3377, BWE_LO, "rdw_lo");
        applyStimulus(16'h0004, 16'h0000, BWE_NONE, "rdw_rd4");
        applyStimulus(16'h0006, 16'h0000, BWE_NONE, "rdw_rd6");
    endtask

    task automatic test_wrap_misalign;
        applyStimulus(16'h0020, 16'hBEEF, BWE_WORD, "wrap_wr");
        applyStimulus(16'h0000, 16'h0000, BWE_NONE, "wrap_rd0");
        applyStimulus(16'hFFE0, 16'h0000, BWE_NONE, "wrap_rdhi");
        applyStimulus(16'h0001, 16'h1234, BWE_HI, "misalign_wr");
        applyStimulus(16'h0000, 16'h0000, BWE_NONE, "misalign_rd");
        applyStimulus(16'h001F, 16'h00C3, BWE_LO, "top_odd_wr");
        applyStimulus(16'h001E, 16'h0000, BWE_NONE, "top_rd");
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(16'(16 + 2*i), 16'(32'h1000 * i + 32'h0101 * i), BWE_WORD, $sformatf("b2b_wr%0d", i));
        end
        for (int i = 0; i < 8; i++) begin
            applyStimulus(16'(16 + 2*i + (i % 2)), 16'h0000, BWE_NONE, $sformatf("b2b_rd%0d", i));
        end
    endtask

    // Sequence the scenarios and print the summary.
    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        rst_n = 1'b0;
        addr  = 16'h0000;
        din   = 16'h0000;
        bwe   = BWE_NONE;
        #12;
        test_reset;
        test_word_writes;
        test_byte_writes;
        test_reset_mid_read;
        test_read_during_write;
        test_wrap_misalign;
        test_back_to_back;
        if (sb.size() != 0) begin
            n_mismatched++;
            $display("[TB] FAIL scoreboard_drain: left=%0d expected=0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
